// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the ahb_master state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LAST,
    ST_ERR
  } mst_state_t;

  // NONSEQ and SEQ are the only transfer types that move data.
  function automatic logic trans_active(input logic [1:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/ahb_master.sv
// AHB-Lite initiator: one command of 1-256 word beats becomes a pipelined bus transaction.
// Optional build macro AHB_MST_BURST_EN: INCR bursts, SEQ beats and BUSY on write starvation.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ADDR  | issuing address phases; the previous beat's data phase may overlap
// LAST  | all addresses accepted, final data phase outstanding
// ERR   | first ERROR cycle seen, waiting for the second to close the command
module ahb_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WID = 32
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_WID-1:0] cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [31:0]         wr_data,
  output logic                rd_valid,
  output logic [31:0]         rd_data,
  output logic                done,
  output logic                done_err,
  output logic [ADDR_WID-1:0] haddr,
  output logic [1:0]          htrans,
  output logic                hwrite,
  output logic [2:0]          hsize,
  output logic [2:0]          hburst,
  output logic [31:0]         hwdata,
  input  logic [31:0]         hrdata,
  input  logic                hready,
  input  logic [1:0]          hresp
);

`ifdef AHB_MST_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  localparam logic [ADDR_WID-1:0] WORD_MASK = ~(ADDR_WID'(3));

  mst_state_t          state_q, state_d;
  logic [ADDR_WID-1:0] addr_q, addr_d;
  logic                write_q, write_d;
  logic [8:0]          remain_q, remain_d;
  logic                first_q, first_d;
  logic [2:0]          burst_q, burst_d;
  logic [31:0]         hwdata_q, hwdata_d;
  logic [31:0]         pend_q, pend_d;
  logic                frz_q, frz_d;
  logic [1:0]          trans_q, trans_d;
  logic                dp_q, dp_d;
  logic                dp_write_q, dp_write_d;

  logic                err_first;
  logic [1:0]          trans_new;
  logic [1:0]          trans_fill;

  assign haddr  = addr_q;
  assign hwrite = write_q;
  assign hsize  = HSIZE_WORD;
  assign hburst = burst_q;
  assign hwdata = hwdata_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    remain_d   = remain_q;
    first_d    = first_q;
    burst_d    = burst_q;
    hwdata_d   = hwdata_q;
    pend_d     = pend_q;
    frz_d      = 1'b0;
    trans_d    = HTRANS_IDLE;
    dp_d       = hready ? 1'b0 : dp_q;
    dp_write_d = dp_write_q;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    htrans     = HTRANS_IDLE;
    done       = 1'b0;
    done_err   = 1'b0;

    err_first  = dp_q && !hready && (hresp == HRESP_ERROR);
    rd_valid   = dp_q && hready && !dp_write_q && (hresp == HRESP_OKAY) && (state_q != ST_ERR);
    rd_data    = rd_valid ? hrdata : 32'd0;

    // The very first beat never shows BUSY; a 1 KB crossing restarts the burst.
    if (BURST_EN) begin
      trans_new  = (first_q || (addr_q[9:0] == 10'd0)) ? HTRANS_NONSEQ : HTRANS_SEQ;
      trans_fill = first_q ? HTRANS_IDLE : HTRANS_BUSY;
    end else begin
      trans_new  = HTRANS_NONSEQ;
      trans_fill = HTRANS_IDLE;
    end

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d  = ST_ADDR;
          addr_d   = cmd_addr & WORD_MASK;
          write_d  = cmd_write;
          remain_d = {1'b0, cmd_len} + 9'd1;
          first_d  = 1'b1;
          burst_d  = (BURST_EN && (cmd_len != 8'd0)) ? HBURST_INCR : HBURST_SINGLE;
        end
      end

      ST_ADDR: begin
        if (err_first) begin
          state_d = ST_ERR;
        end else begin
          // A waited address phase replays whatever was shown before the wait.
          if (frz_q) begin
            htrans = trans_q;
          end else if (write_q && !wr_valid) begin
            htrans = trans_fill;
          end else begin
            htrans   = trans_new;
            wr_ready = write_q;
          end
          if (wr_ready) begin
            pend_d = wr_data;
          end
          if (hready && trans_active(htrans)) begin
            addr_d     = addr_q + ADDR_WID'(4);
            remain_d   = remain_q - 9'd1;
            first_d    = 1'b0;
            dp_d       = 1'b1;
            dp_write_d = write_q;
            if (write_q) begin
              hwdata_d = wr_ready ? wr_data : pend_q;
            end
            if (remain_q == 9'd1) begin
              state_d = ST_LAST;
            end
          end
          frz_d   = !hready;
          trans_d = htrans;
        end
      end

      ST_LAST: begin
        if (err_first) begin
          state_d = ST_ERR;
        end else if (hready) begin
          done     = 1'b1;
          done_err = (hresp == HRESP_ERROR);
          state_d  = ST_IDLE;
        end
      end

      ST_ERR: begin
        if (hready) begin
          done     = 1'b1;
          done_err = 1'b1;
          dp_d     = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      remain_q   <= 9'd0;
      first_q    <= 1'b0;
      burst_q    <= HBURST_SINGLE;
      hwdata_q   <= 32'd0;
      pend_q     <= 32'd0;
      frz_q      <= 1'b0;
      trans_q    <= HTRANS_IDLE;
      dp_q       <= 1'b0;
      dp_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      remain_q   <= remain_d;
      first_q    <= first_d;
      burst_q    <= burst_d;
      hwdata_q   <= hwdata_d;
      pend_q     <= pend_d;
      frz_q      <= frz_d;
      trans_q    <= trans_d;
      dp_q       <= dp_d;
      dp_write_q <= dp_write_d;
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// Self-checking bench for ahb_master: directed scenarios plus random commands against a word-memory slave model.
module tb_ahb_master;
  import ahb_pkg::*;

`ifdef AHB_MST_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done, done_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] hwdata, hrdata;
  logic        hready;
  logic [1:0]  hresp;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] preset_words [$];

  ahb_master #(.ADDR_WID(32)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .done_err(done_err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  // Runs one command from acceptance to done, predicting every bus cycle from the
  // transfer rules: beat i lives at base+4i, data follows its accepted address.
  task automatic run_cmd(input bit wr, input logic [31:0] a, input int len,
                         input int stall_pct, input int starve_pct,
                         input logic [63:0] starve_mask, input int first_wait,
                         input int err_beat);
    int          total, issued, wptr, cyc, dpi, dwait, err_ph, rd_cnt;
    bit          dpv, prev_wait, act_prev, act, wv, fin, comp, last_done, acc, exp_wrr, clean;
    logic [31:0] base, cur;
    logic [1:0]  exp_htr;
    logic [2:0]  exp_burst;
    logic [31:0] words [$];

    total = len + 1;
    base  = {a[31:2], 2'b00};
    issued = 0; wptr = 0; cyc = 0; dpi = 0; dwait = 0; err_ph = 0; rd_cnt = 0;
    dpv = 0; prev_wait = 0; act_prev = 0; wv = 0; fin = 0;
    clean = (stall_pct == 0) && (starve_pct == 0) && (starve_mask == 64'd0) &&
            (first_wait == 0) && (err_beat < 0);
    exp_burst = (BURST && len > 0) ? HBURST_INCR : HBURST_SINGLE;
    for (int i = 0; i < total; i++)
      words.push_back(preset_words.size() > 0 ? preset_words.pop_front() : $urandom);

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = 8'(len);
    hready = 1'b1; hresp = HRESP_OKAY; wr_valid = 1'b0; hrdata = $urandom;
    @(negedge hclk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge hclk); #1;
    cmd_write = ~wr; cmd_addr = ~a; cmd_len = 8'($urandom);

    while (!fin && cyc < 4000) begin
      cyc++;
      if (err_ph != 0) begin
        hresp = HRESP_ERROR; hready = 1'b1;
      end else if (dpv && dpi == err_beat) begin
        err_ph = 1; hresp = HRESP_ERROR; hready = 1'b0;
      end else begin
        hresp = HRESP_OKAY; hready = !(dpv && dwait > 0);
      end
      hrdata = (dpv && !wr) ? mem_rd(base + 32'(4 * dpi)) : $urandom;
      if (!wr) wv = 1'(($urandom));
      else if (!prev_wait)
        wv = (wptr < total) && !(cyc < 64 && starve_mask[cyc[5:0]]) &&
             (int'($urandom_range(99)) >= starve_pct);
      wr_valid = wv;
      wr_data  = (wr && wv && wptr < total) ? words[wptr] : $urandom;
      @(negedge hclk);

      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      chk("hsize", 32'(hsize), 32'(HSIZE_WORD));
      if (err_ph == 1) begin
        chk("err1_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        chk("err1_outs", 32'({rd_valid, wr_ready, done}), 32'd0);
        err_ph = 2;
      end else if (err_ph == 2) begin
        chk("err2_done", 32'({done, done_err}), 32'b11);
        chk("err2_rd_valid", 32'(rd_valid), 32'd0);
        chk("err2_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        fin = 1;
      end else begin
        comp = dpv && hready;
        acc  = 0;
        if (dpv && wr) chk("hwdata", hwdata, words[dpi]);
        chk("rd_valid", 32'(rd_valid), 32'(comp && !wr));
        if (comp && !wr) begin
          chk("rd_data", rd_data, mem_rd(base + 32'(4 * dpi)));
          rd_cnt++;
        end
        if (comp && wr) mem[base + 32'(4 * dpi)] = words[dpi];
        last_done = comp && (dpi == total - 1);
        chk("done", 32'({done, done_err}), 32'({last_done, 1'b0}));

        if (issued < total) begin
          cur = base + 32'(4 * issued);
          act = prev_wait ? act_prev : (!wr || wv);
          if (act)
            exp_htr = (!BURST || issued == 0 || cur[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
          else
            exp_htr = (BURST && issued > 0) ? HTRANS_BUSY : HTRANS_IDLE;
          exp_wrr = wr && act && !prev_wait;
          chk("htrans", 32'(htrans), 32'(exp_htr));
          chk("haddr", haddr, cur);
          chk("wr_ready", 32'(wr_ready), 32'(exp_wrr));
          if (act) chk("hwrite_hburst", 32'({hwrite, hburst}), 32'({wr, exp_burst}));
          if (exp_wrr) wptr++;
          act_prev = act;
          if (act && hready) begin
            issued++;
            acc = 1;
          end
        end else begin
          chk("htrans_tail", 32'(htrans), 32'(HTRANS_IDLE));
          chk("wr_ready_tail", 32'(wr_ready), 32'd0);
        end

        if (hready) begin
          dpv = acc;
          dpi = issued - 1;
          if (dpi == 0) dwait = first_wait;
          else dwait = (int'($urandom_range(99)) < stall_pct) ? int'($urandom_range(3, 1)) : 0;
        end else begin
          dwait--;
        end
        prev_wait = !hready;
        if (last_done) fin = 1;
      end
      @(posedge hclk); #1;
    end

    chk("cmd_finished", 32'(fin), 32'd1);
    if (err_beat < 0) begin
      if (!wr) chk("rd_count", 32'(rd_cnt), 32'(total));
      chk("beats_issued", 32'(issued), 32'(total));
    end else begin
      if (!wr) chk("rd_count_err", 32'(rd_cnt), 32'(err_beat));
      chk("beats_issued_err", 32'(issued), 32'(err_beat + 1));
    end
    if (clean) chk("done_cycle", 32'(cyc), 32'(total + 1));
    cmd_valid = 1'b0; wr_valid = 1'b0; hready = 1'b1; hresp = HRESP_OKAY;
  endtask

  initial begin
    logic [31:0] ra;
    int          rl;
    bit          rw;

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h1234_5678; cmd_len = 8'd3;
    wr_valid = 1'b0; wr_data = 32'hFFFF_FFFF;
    hrdata = 32'hDEAD_BEEF; hready = 1'b1; hresp = HRESP_OKAY;
    #2;
    chk("rst_bus", 32'({htrans, hwrite, hsize, hburst}), 32'({HTRANS_IDLE, 1'b0, 3'b010, 3'b000}));
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_ctrl", 32'({cmd_ready, wr_ready, rd_valid, done, done_err}), 32'b10000);
    chk("rst_rd_data", rd_data, 32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;

    // read burst of 4 from 0x100, slave data 0xA0..0xA3
    for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
    run_cmd(1'b0, 32'h100, 3, 0, 0, 64'd0, 0, -1);

    // write of two words with a two-cycle starvation gap
    preset_words.push_back(32'h11);
    preset_words.push_back(32'h22);
    run_cmd(1'b1, 32'h40, 1, 0, 0, 64'b1100, 0, -1);
    chk("wr_word0", mem_rd(32'h40), 32'h11);
    chk("wr_word1", mem_rd(32'h44), 32'h22);

    // two wait states on the first data phase
    run_cmd(1'b0, 32'h180, 1, 0, 0, 64'd0, 2, -1);

    // 1 KB crossing
    run_cmd(1'b0, 32'h3F8, 3, 0, 0, 64'd0, 0, -1);

    // ERROR on beat 2 of 4
    run_cmd(1'b0, 32'h500, 3, 0, 0, 64'd0, 0, 1);

    // single beat, unaligned start, address wrap, full 256-beat burst
    run_cmd(1'b1, 32'h0000_0203, 0, 0, 0, 64'd0, 0, -1);
    run_cmd(1'b0, 32'h0000_0200, 0, 0, 0, 64'd0, 0, -1);
    run_cmd(1'b0, 32'hFFFF_FFF8, 3, 0, 0, 64'd0, 0, -1);
    run_cmd(1'b1, 32'h0000_0F00, 255, 20, 20, 64'd0, 1, -1);
    run_cmd(1'b0, 32'h0000_0F00, 255, 0, 0, 64'd0, 0, -1);

    // reset during beat 2 of a read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200; cmd_len = 8'd3;
    hready = 1'b1; hresp = HRESP_OKAY; hrdata = 32'h5555_AAAA;
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    @(posedge hclk); #1;
    chk("mid_haddr", haddr, 32'h204);
    chk("mid_htrans", 32'(htrans), 32'(BURST ? HTRANS_SEQ : HTRANS_NONSEQ));
    #2;
    hresetn = 1'b0;
    #1;
    chk("arst_bus", 32'({htrans, hwrite, hburst}), 32'({HTRANS_IDLE, 1'b0, 3'b000}));
    chk("arst_haddr", haddr, 32'd0);
    chk("arst_ctrl", 32'({cmd_ready, wr_ready, rd_valid, done, done_err}), 32'b10000);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("arst_no_done", 32'({done, rd_valid}), 32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    run_cmd(1'b0, 32'h200, 1, 0, 0, 64'd0, 0, -1);

    // random commands
    for (int n = 0; n < 40; n++) begin
      rw = 1'($urandom);
      if ($urandom_range(2) == 0)
        ra = 32'($urandom_range(15, 1)) * 32'h400 - 32'($urandom_range(6, 1)) * 32'd4;
      else
        ra = $urandom;
      rl = ($urandom_range(9) == 0) ? int'($urandom_range(255)) : int'($urandom_range(12));
      run_cmd(rw, ra, rl, int'($urandom_range(40)), int'($urandom_range(40)), 64'd0,
              int'($urandom_range(2)),
              ($urandom_range(5) == 0) ? int'($urandom_range(rl)) : -1);
      if ($urandom_range(1) == 0) begin
        run_cmd(1'b0, ra, rl, int'($urandom_range(30)), 0, 64'd0, 0, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
